// File: rtl/dma_copy_ctrl_pkg.sv
// dma_pkg: shared FSM state encoding and AXI constants for the DMA copy sequencer
package dma_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/dma_copy_ctrl_wr_join.sv
// dma_wr_join: remembers AW and W handshakes (clk_i, rst_ni, clr_i, aw_hs_i, w_hs_i in; both_done_o out)
module dma_wr_join (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic aw_hs_i,
  input  logic w_hs_i,
  output logic both_done_o
);
  logic aw_q, w_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      aw_q <= 1'b0;
      w_q  <= 1'b0;
    end else begin
      aw_q <= aw_q | aw_hs_i;
      w_q  <= w_q | w_hs_i;
    end
  end
  assign both_done_o = aw_q & w_q;
endmodule

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: word-by-word AXI4-Lite copy sequencer (src/dst/length/start in; done/error/busy out; M_AXI master)
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   address_src,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   address_dst,
  input  logic [31:0]                     length,
  input  logic                            start,
  output logic                            done,
  output logic                            error,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);
  state_e state_q;
  logic start_q, done_q, error_q, busy_q;
  logic arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] src_q, dst_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] data_q;
  logic [29:0] words_q, len_words;
  logic both_done, unused_len;
  assign len_words  = length[31:2];
  assign unused_len = ^length[1:0];
  dma_wr_join u_join (
    .clk_i      (M_AXI_ACLK),
    .rst_ni     (M_AXI_ARESETN),
    .clr_i      (state_q == WR && both_done),
    .aw_hs_i    (awvalid_q & M_AXI_AWREADY),
    .w_hs_i     (wvalid_q & M_AXI_WREADY),
    .both_done_o(both_done)
  );
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      words_q   <= '0;
      data_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: if (start && !start_q) begin
          src_q     <= address_src;
          dst_q     <= address_dst;
          words_q   <= len_words;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          busy_q    <= 1'b1;
          arvalid_q <= len_words != '0;
          state_q   <= len_words == '0 ? DONE : RD_ADDR;
        end
        RD_ADDR: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          rready_q  <= 1'b0;
          data_q    <= M_AXI_RDATA;
          error_q   <= M_AXI_RRESP != RESP_OKAY;
          awvalid_q <= M_AXI_RRESP == RESP_OKAY;
          wvalid_q  <= M_AXI_RRESP == RESP_OKAY;
          state_q   <= M_AXI_RRESP != RESP_OKAY ? DONE : WR;
        end
        WR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY) wvalid_q <= 1'b0;
          if (both_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          bready_q <= 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end else begin
            src_q     <= src_q + C_M_AXI_ADDR_WIDTH'(WORD_BYTES);
            dst_q     <= dst_q + C_M_AXI_ADDR_WIDTH'(WORD_BYTES);
            words_q   <= words_q - 30'd1;
            arvalid_q <= words_q != 30'd1;
            state_q   <= words_q == 30'd1 ? DONE : RD_ADDR;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done          = done_q;
  assign error         = error_q;
  assign busy          = busy_q;
  assign M_AXI_ARADDR  = src_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_AWADDR  = dst_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
endmodule

// File: tb/tb_dma_copy_ctrl.sv
// tb_dma_copy_ctrl: directed and randomized copies against an AXI4-Lite memory responder and a word-list reference model
module tb_dma_copy_ctrl;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0;
  logic done, error, busy;
  logic [31:0] araddr, awaddr, wdata;
  logic [31:0] rdata = '0;
  logic [2:0] arprot, awprot;
  logic [3:0] wstrb;
  logic [1:0] rresp = '0, bresp = '0;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  always #5 clk = ~clk;

  dma_copy_ctrl dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .address_src(src), .address_dst(dst), .length(len), .start(start),
    .done(done), .error(error), .busy(busy),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  int checks = 0, failures = 0, proto_viol = 0, cyc = 0;
  logic d1, e1, b1;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_log[$], aw_log[$], wa_log[$], wd_log[$];
  int rnd_max = 0, fix_aw = 0, fix_w = 0;
  logic fix_mode = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction
  function automatic int pick(input int ch);
    if (fix_mode) return ch == 1 ? fix_aw : ch == 2 ? fix_w : 0;
    return rnd_max > 0 ? int'($urandom_range(0, rnd_max)) : 0;
  endfunction

  logic rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  logic arm_ar = 0, arm_r = 0, arm_aw = 0, arm_w = 0, arm_b = 0;
  logic p_ar = 0, p_aw = 0, p_w = 0;
  logic [31:0] rd_addr = 0, got_aw = 0, got_w = 0, p_araddr = 0, p_awaddr = 0, p_wdata = 0;
  int cnt_ar = 0, cnt_r = 0, cnt_aw = 0, cnt_w = 0, cnt_b = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      {rd_pend, aw_got, w_got, b_pend, p_ar, p_aw, p_w} = '0;
      {arm_ar, arm_r, arm_aw, arm_w, arm_b} = '0;
    end else begin
      if (p_ar && !(arvalid && araddr == p_araddr)) proto_viol++;
      if (p_aw && !(awvalid && awaddr == p_awaddr)) proto_viol++;
      if (p_w && !(wvalid && wdata == p_wdata)) proto_viol++;
      if (arvalid && (rd_pend || aw_got || w_got || b_pend)) proto_viol++;
      if ((awvalid || wvalid) && rd_pend) proto_viol++;
      if (arprot != 3'b000 || awprot != 3'b000) proto_viol++;
      if (arvalid && arready) begin ar_log.push_back(araddr); rd_pend = 1; rd_addr = araddr; arm_ar = 0; end
      if (rvalid && rready) begin rd_pend = 0; arm_r = 0; end
      if (awvalid && awready) begin aw_log.push_back(awaddr); aw_got = 1; got_aw = awaddr; arm_aw = 0; end
      if (wvalid && wready) begin w_got = 1; got_w = wdata; arm_w = 0; if (wstrb != 4'hF) proto_viol++; end
      if (bvalid && bready) begin b_pend = 0; arm_b = 0; end
      if (aw_got && w_got && !b_pend) begin
        wa_log.push_back(got_aw); wd_log.push_back(got_w);
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      p_ar = arvalid && !arready; p_araddr = araddr;
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata  = wdata;
    end
  end

  always @(negedge clk) begin
    arready = 0; awready = 0; wready = 0;
    if (!rstn) begin
      rvalid = 0; bvalid = 0;
    end else begin
      if (arvalid && !rd_pend) begin
        if (!arm_ar) begin cnt_ar = pick(0); arm_ar = 1; end
        if (cnt_ar == 0) arready = 1; else cnt_ar--;
      end
      if (!rd_pend) rvalid = 0;
      else if (!rvalid) begin
        if (!arm_r) begin cnt_r = pick(0); arm_r = 1; end
        if (cnt_r == 0) begin
          rvalid = 1; rdata = memval(rd_addr); rresp = rd_addr == err_addr ? 2'b10 : 2'b00;
        end else cnt_r--;
      end
      if (awvalid && !aw_got) begin
        if (!arm_aw) begin cnt_aw = pick(1); arm_aw = 1; end
        if (cnt_aw == 0) awready = 1; else cnt_aw--;
      end
      if (wvalid && !w_got) begin
        if (!arm_w) begin cnt_w = pick(2); arm_w = 1; end
        if (cnt_w == 0) wready = 1; else cnt_w--;
      end
      if (!b_pend) bvalid = 0;
      else if (!bvalid) begin
        if (!arm_b) begin cnt_b = pick(0); arm_b = 1; end
        if (cnt_b == 0) begin bvalid = 1; bresp = 2'b00; end else cnt_b--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ar_log.delete(); aw_log.delete(); wa_log.delete(); wd_log.delete();
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    clear_logs();
    src = s; dst = d; len = l; start = 1; cyc = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
      if (cyc == 1) begin start = 0; d1 = done; e1 = error; b1 = busy; end
    end while (!(done && cyc > 1) && cyc < 3000);
    chk("copy_finished", 32'(cyc < 3000), 1);
  endtask

  // expected behaviour: words up to (not including) the failing read are copied in order
  task automatic check_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int err_idx);
    int k, nar;
    k = err_idx < n ? err_idx : n;
    nar = err_idx < n ? err_idx + 1 : n;
    chk("n_reads", ar_log.size(), nar);
    chk("n_aw", aw_log.size(), k);
    chk("n_writes", wa_log.size(), k);
    for (int i = 0; i < nar && i < ar_log.size(); i++) chk("araddr", ar_log[i], s + 32'(4 * i));
    for (int i = 0; i < k && i < wa_log.size(); i++) begin
      chk("wr_addr", wa_log[i], d + 32'(4 * i));
      chk("wr_data", wd_log[i], memval(s + 32'(4 * i)));
    end
    chk("done", 32'(done), 1);
    chk("error", 32'(error), 32'(err_idx < n));
    chk("busy_end", 32'(busy), 0);
    chk("protocol", proto_viol, 0);
  endtask

  initial begin
    logic [31:0] s, d;
    int n;
    logic seen;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("wstrb", 32'(wstrb), 32'hF);
    @(negedge clk);

    run_copy(32'h1000, 32'h2000, 32'd3);
    chk("len0_latency", cyc, 2);
    chk("len0_busy_pulse", 32'(b1), 1);
    check_copy(32'h1000, 32'h2000, 0, 99);

    mem[32'h1000] = 32'hDEADBEEF;
    mem[32'h1004] = 32'h01234567;
    run_copy(32'h1000, 32'h2000, 32'd8);
    chk("two_word_latency", cyc, 12);
    check_copy(32'h1000, 32'h2000, 2, 99);
    if (wd_log.size() == 2) begin
      chk("word0", wd_log[0], 32'hDEADBEEF);
      chk("word1", wd_log[1], 32'h01234567);
    end

    rnd_max = 5;
    for (int i = 0; i < 3; i++) begin
      run_copy(32'h1000, 32'h2000, 32'd8);
      check_copy(32'h1000, 32'h2000, 2, 99);
    end
    rnd_max = 0; fix_mode = 1; fix_aw = 0; fix_w = 3;
    run_copy(32'h1000, 32'h2000, 32'd8);
    check_copy(32'h1000, 32'h2000, 2, 99);
    fix_aw = 3; fix_w = 0;
    run_copy(32'h1000, 32'h2000, 32'd8);
    check_copy(32'h1000, 32'h2000, 2, 99);
    fix_mode = 0;

    run_copy(32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'd16);
    check_copy(32'hFFFF_FFF8, 32'hFFFF_FFF4, 4, 99);
    for (int i = 0; i < 5; i++) begin
      rnd_max = int'($urandom_range(0, 5));
      s = $urandom() & ~32'h3;
      d = $urandom() & ~32'h3;
      n = int'($urandom_range(1, 5));
      run_copy(s, d, 32'(4 * n) | 32'($urandom_range(0, 3)));
      check_copy(s, d, n, 99);
    end
    rnd_max = 0;

    err_addr = 32'h3004;
    run_copy(32'h3000, 32'h4000, 32'd12);
    check_copy(32'h3000, 32'h4000, 3, 1);
    err_addr = 32'hFFFF_FFFF;
    run_copy(32'h3000, 32'h4000, 32'd4);
    chk("relaunch_done_clr", 32'(d1), 0);
    chk("relaunch_error_clr", 32'(e1), 0);
    chk("relaunch_busy", 32'(b1), 1);
    check_copy(32'h3000, 32'h4000, 1, 99);

    clear_logs();
    src = 32'h5000; dst = 32'h6000; len = 32'd16; start = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 10) start = 0;
      if (i == 11) start = 1;
    end
    start = 0;
    repeat (3) @(negedge clk);
    check_copy(32'h5000, 32'h6000, 4, 99);

    clear_logs();
    fix_mode = 1; fix_aw = 6; fix_w = 6;
    src = 32'h7000; dst = 32'h8000; len = 32'd8; start = 1;
    @(posedge clk); @(negedge clk); start = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (awvalid) seen = 1; else begin @(posedge clk); @(negedge clk); end
    end
    chk("reached_wr", 32'(seen), 1);
    rstn = 0;
    @(posedge clk); @(negedge clk);
    rstn = 1;
    chk("mid_rst_arvalid", 32'(arvalid), 0);
    chk("mid_rst_awvalid", 32'(awvalid), 0);
    chk("mid_rst_wvalid", 32'(wvalid), 0);
    chk("mid_rst_rready", 32'(rready), 0);
    chk("mid_rst_bready", 32'(bready), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    fix_mode = 0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(arvalid | busy), 0);
    run_copy(32'h7000, 32'h8000, 32'd8);
    chk("fresh_latency", cyc, 12);
    check_copy(32'h7000, 32'h8000, 2, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_copy_ctrl.md
Name: dma_copy_ctrl

Overview:
- Sequencer behind the DMA register slave. Copies `length` bytes from `address_src` to `address_dst`, one 32-bit word at a time.
- Drives an AXI4-Lite master, single beat per transaction: read one word, then write it.
- Reports `done`/`error` back to the register slave.
- Sits between the register slave outputs and the interconnect master port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, master address width; matches `address_src`/`address_dst` width.
- C_M_AXI_DATA_WIDTH, 32, master data width; only 32 is supported.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  synchronous reset, active-low
- address_src  in  32  source byte address, word aligned
- address_dst  in  32  destination byte address, word aligned
- length  in  32  byte count; bits [1:0] ignored
- start  in  1  level from control register; rising edge launches a copy
- done  out  1  high when the last copy finished (or aborted); cleared on launch
- error  out  1  high when the last copy aborted on a non-OKAY response
- busy  out  1  high from launch until completion
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in  AXI4-Lite read address channel
- M_AXI_RDATA/RRESP/RVALID in, RREADY out  read data channel
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in  write address channel
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel
- M_AXI_BRESP/BVALID in, BREADY out  write response channel

Behaviour:
- Reset (ARESETN=0 at clock edge):
  - State goes to IDLE.
  - All VALID/READY outputs 0; done=0, error=0, busy=0.
  - Address and data registers 0; start_q=0.
  - Reset mid-transfer aborts immediately; outstanding bus transactions are abandoned.
- Fixed outputs: ARPROT=AWPROT=3'b000, WSTRB=4'hF.
- Launch:
  - start_q is start registered each cycle; launch = start & ~start_q while in IDLE.
  - On launch, latch src, dst and words = length[31:2].
  - done<=0, error<=0, busy<=1.
  - Next state is RD_ADDR, or DONE if words==0.
- Start edges outside IDLE are ignored; start held high does not relaunch.
- States:
  - IDLE: wait for launch.
  - RD_ADDR: ARVALID=1, ARADDR=src. On ARVALID&ARREADY, drop ARVALID and go to RD_DATA.
  - RD_DATA: RREADY=1. On RVALID&RREADY:
    - capture RDATA into data_q;
    - RRESP!=OKAY: error<=1, go to DONE;
    - otherwise go to WR.
  - WR: AWVALID=1 with AWADDR=dst; WVALID=1 with WDATA=data_q.
    - Each VALID stays high until its own handshake, then drops.
    - AW and W may complete in the same or different cycles, in either order.
    - When both have completed, go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID&BREADY:
    - BRESP!=OKAY: error<=1, go to DONE;
    - else src+=4, dst+=4, words-=1;
    - go to DONE if the old words==1, else RD_ADDR.
  - DONE: one cycle; done<=1, busy<=0, go to IDLE. done and error hold until the next launch.
- AXI rules:
  - No VALID deasserts before its handshake.
  - ADDR/DATA stay stable while VALID is high.
  - VALID never depends combinationally on READY.
  - At most one outstanding transaction.
- Arithmetic:
  - Addresses increment modulo 2^32; wrap past 0xFFFFFFFC is allowed, not flagged.
  - words is a 30-bit down-counter.
- Latency:
  - Zero-wait copy of N words: launch→done = 1 + 5N + 1 cycles (RD_ADDR, RD_DATA, WR, WR_RESP plus handshake registration).
  - length<4: done 2 cycles after the start edge.
- Outputs are registered; no combinational path from any AXI input to any AXI output.

Decomposition:
- Package dma_pkg:
  - state enum {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE};
  - RESP_OKAY=2'b00;
  - WORD_BYTES=4.
- One sub-module is natural: dma_wr_join. It tracks the AW/W independent-completion flags and raises both_done. Everything else stays in the top FSM.

Test Plan:
- length=0, pulse start → no ARVALID ever; done=1 two cycles after the edge, error=0, busy pulses.
- src=0x1000, dst=0x2000, length=8, memory {0x1000:0xDEADBEEF, 0x1004:0x01234567}, zero-wait slave → writes 0x2000=0xDEADBEEF, then 0x2004=0x01234567; ARADDR sequence 0x1000,0x1004; done after 12 cycles.
- Same copy with random 0–5 cycle READY/VALID delays, and AWREADY 3 cycles before WREADY (and vice versa) → identical memory result; VALIDs held stable until handshake; exactly one AW and one W per word.
- length=12, second read returns RRESP=2'b10 → only the first word is written, no second AW; error=1, done=1; next launch clears both.
- start held high for 100 cycles during a 4-word copy, plus a second rising edge mid-transfer → exactly one copy performed.
- ARESETN low for 1 cycle during WR with AWVALID=1 → next cycle all VALIDs 0, done=0, busy=0, FSM idle; a subsequent start edge completes a fresh copy correctly.
